// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU requester slice.
//   ALU_W      - ALU datapath width (16).
//   alu_op_e   - 3-bit ALU opcode encoding.
//   alu_ref()  - behavioural ALU used by the optional result checker.
package alu_pkg;

    localparam int unsigned ALU_W = 16;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_NOR = 3'b101,
        ALU_SLT = 3'b110,
        ALU_SLL = 3'b111
    } alu_op_e;

    // SLT is a signed compare returning 1/0; SLL shifts by b[3:0] only.
    function automatic logic [ALU_W-1:0] alu_ref(input logic [ALU_W-1:0] a,
                                                 input logic [ALU_W-1:0] b,
                                                 input logic [2:0]       op);
        logic [ALU_W-1:0] r;
        r = '0;
        case (alu_op_e'(op))
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_NOR: r = ~(a | b);
            ALU_SLT: r = ($signed(a) < $signed(b)) ? ALU_W'(1) : '0;
            ALU_SLL: r = a << b[3:0];
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// alu_seq_fifo: synchronous FIFO with a registered head word.
//   clk, rst      - clock, synchronous active-high reset
//   push_i        - write push_data_i at the tail this edge
//   push_data_i   - tail write data
//   pop_i         - drop the head entry this edge (caller guarantees non-empty)
//   count_o       - number of stored entries (0..DEPTH)
//   head_o        - registered copy of the oldest entry
module alu_seq_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [W-1:0]               push_data_i,
    input  logic                       pop_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [W-1:0]               head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     head_q, head_d;

    always_comb begin
        rd_d   = rd_q + PTR_W'(pop_i);
        wr_d   = wr_q + PTR_W'(push_i);
        cnt_d  = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
        head_d = head_q;
        // Head register tracks the entry at the post-edge read pointer.
        // When the FIFO is (or becomes) empty, a push bypasses straight
        // into the head because mem has not been written yet.
        if (pop_i) begin
            if (cnt_q > CNT_W'(1)) begin
                head_d = mem_q[rd_d];
            end else if (push_i) begin
                head_d = push_data_i;
            end
        end else if ((cnt_q == '0) && push_i) begin
            head_d = push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    assign count_o = cnt_q;
    assign head_o  = head_q;

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: registered request front end for the combinational ALU.
// Requests (req_*) load a stage register that drives the ALU; one cycle later
// {alu_out, alu_zero, tag} is pushed into an in-order response FIFO (rsp_*).
//   clk, rst                              - clock, synchronous active-high reset
//   req_valid/req_ready, req_a/b/op/tag   - request handshake and payload
//   alu_input1/alu_input2/alu_control     - to ALU, from the stage register
//   alu_out/alu_zero                      - from ALU
//   rsp_valid/rsp_ready, rsp_data/zero/tag - response handshake and payload
//   err_cnt                               - saturating checker mismatch count
// Optional build macro ALU_SEQ_CHECK_EN enables the result checker; without it
// err_cnt is tied to zero.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [ALU_W-1:0] req_a,
    input  logic [ALU_W-1:0] req_b,
    input  logic [2:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic [ALU_W-1:0] alu_input1,
    output logic [ALU_W-1:0] alu_input2,
    output logic [2:0]       alu_control,
    input  logic [ALU_W-1:0] alu_out,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ALU_W-1:0] rsp_data,
    output logic             rsp_zero,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [7:0]       err_cnt
);

    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned FIFO_W = ALU_W + 1 + TAG_W;

    logic             stage_valid_q, stage_valid_d;
    logic [ALU_W-1:0] a_q, a_d;
    logic [ALU_W-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic             accept;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] fifo_count;
    logic [FIFO_W-1:0] fifo_head;
    logic [FIFO_W-1:0] push_word;

    // Occupancy plus the in-flight stage must leave room; one extra bit keeps
    // the sum from wrapping.
    assign req_ready = ({1'b0, fifo_count} + (CNT_W+1)'(stage_valid_q)) < (CNT_W+1)'(DEPTH);
    assign accept    = req_valid && req_ready;
    assign push      = stage_valid_q;
    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign push_word = {alu_out, alu_zero, tag_q};

    always_comb begin
        stage_valid_d = accept;
        a_d   = a_q;
        b_d   = b_q;
        op_d  = op_q;
        tag_d = tag_q;
        if (accept) begin
            a_d   = req_a;
            b_d   = req_b;
            op_d  = req_op;
            tag_d = req_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid_q <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= '0;
            tag_q         <= '0;
        end else begin
            stage_valid_q <= stage_valid_d;
            a_q           <= a_d;
            b_q           <= b_d;
            op_q          <= op_d;
            tag_q         <= tag_d;
        end
    end

    assign alu_input1  = a_q;
    assign alu_input2  = b_q;
    assign alu_control = op_q;

    alu_seq_fifo #(
        .DEPTH (DEPTH),
        .W     (FIFO_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_word),
        .pop_i       (pop),
        .count_o     (fifo_count),
        .head_o      (fifo_head)
    );

    assign rsp_data = fifo_head[FIFO_W-1 -: ALU_W];
    assign rsp_zero = fifo_head[TAG_W];
    assign rsp_tag  = fifo_head[TAG_W-1:0];

`ifdef ALU_SEQ_CHECK_EN
    logic [ALU_W-1:0] ref_res;
    logic             ref_zero;
    logic             mismatch;
    logic [7:0]       err_q, err_d;

    always_comb begin
        ref_res  = alu_ref(a_q, b_q, op_q);
        ref_zero = (ref_res == '0);
        mismatch = stage_valid_q && ((alu_out != ref_res) || (alu_zero != ref_zero));
        err_d    = err_q;
        if (mismatch && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

    localparam int DEPTH = 2;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [15:0]      req_a, req_b;
    logic [2:0]       req_op;
    logic [TAG_W-1:0] req_tag;
    logic [15:0]      alu_input1, alu_input2;
    logic [2:0]       alu_control;
    logic [15:0]      alu_out;
    logic             alu_zero;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [15:0]      rsp_data;
    logic             rsp_zero;
    logic [TAG_W-1:0] rsp_tag;
    logic [7:0]       err_cnt;

    bit alu_bad = 0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_control(alu_control),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_tag(rsp_tag),
        .err_cnt(err_cnt)
    );

    // Behavioural ALU, straight from the opcode table.
    function automatic logic [15:0] good_alu(input logic [15:0] a, input logic [15:0] b,
                                             input logic [2:0] op);
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~(a | b);
            3'd6: return (sa < sb) ? 16'd1 : 16'd0;
            default: return a << b[3:0];
        endcase
    endfunction

    // Bench-side ALU attached to the DUT; can be made to answer ADD 5+6 wrongly.
    function automatic logic [15:0] bench_alu(input logic [15:0] a, input logic [15:0] b,
                                              input logic [2:0] op, input bit bad);
        if (bad && op == 3'd0 && a == 16'd5 && b == 16'd6) return 16'd12;
        return good_alu(a, b, op);
    endfunction

    assign alu_out  = bench_alu(alu_input1, alu_input2, alu_control, alu_bad);
    assign alu_zero = (alu_out == 16'd0);

    typedef struct {
        logic [15:0]      data;
        logic             zero;
        logic [TAG_W-1:0] tag;
    } rsp_t;

    // Reference model state.
    rsp_t             q[$];
    bit               m_stage_v;
    logic [15:0]      m_a, m_b;
    logic [2:0]       m_op;
    logic [TAG_W-1:0] m_tag;
    int               m_err;
    logic [TAG_W-1:0] popped[$];
    bit               last_acc;

    task automatic model_clear();
        q.delete();
        m_stage_v = 0;
        m_a = '0; m_b = '0; m_op = '0; m_tag = '0;
        m_err = 0;
    endtask

    // One clock cycle: compare outputs with the model, drive inputs, advance model.
    // Entered and left just after a falling edge.
    task automatic step(input bit v, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] op, input logic [TAG_W-1:0] tag, input bit rr);
        bit   exp_ready, acc, pop;
        rsp_t e;
        exp_ready = (q.size() + (m_stage_v ? 1 : 0)) < DEPTH;
        n_cmp++;
        if (req_ready !== exp_ready) begin
            n_err++; $display("FAIL req_ready: got %0b expected %0b", req_ready, exp_ready);
        end
        n_cmp++;
        if (rsp_valid !== (q.size() != 0)) begin
            n_err++; $display("FAIL rsp_valid: got %0b expected %0b", rsp_valid, q.size() != 0);
        end
        if (q.size() != 0) begin
            n_cmp++;
            if (rsp_data !== q[0].data || rsp_zero !== q[0].zero || rsp_tag !== q[0].tag) begin
                n_err++;
                $display("FAIL rsp_head: got data=%0h zero=%0b tag=%0h expected data=%0h zero=%0b tag=%0h",
                         rsp_data, rsp_zero, rsp_tag, q[0].data, q[0].zero, q[0].tag);
            end
        end
        n_cmp++;
        if (alu_input1 !== m_a || alu_input2 !== m_b || alu_control !== m_op) begin
            n_err++;
            $display("FAIL alu_drive: got %0h %0h %0h expected %0h %0h %0h",
                     alu_input1, alu_input2, alu_control, m_a, m_b, m_op);
        end
        n_cmp++;
        if (err_cnt !== m_err[7:0]) begin
            n_err++; $display("FAIL err_cnt: got %0d expected %0d", err_cnt, m_err);
        end

        req_valid = v; req_a = a; req_b = b; req_op = op; req_tag = tag; rsp_ready = rr;
        acc = v && exp_ready;
        pop = rr && (q.size() != 0);
        last_acc = acc;
        if (pop) popped.push_back(rsp_tag);

        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (m_stage_v) begin
            e.data = bench_alu(m_a, m_b, m_op, alu_bad);
            e.zero = (e.data == 16'd0);
            e.tag  = m_tag;
            q.push_back(e);
`ifdef ALU_SEQ_CHECK_EN
            if (e.data != good_alu(m_a, m_b, m_op) && m_err < 255) m_err++;
`endif
        end
        m_stage_v = acc;
        if (acc) begin
            m_a = a; m_b = b; m_op = op; m_tag = tag;
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit rr);
        step(0, $urandom, $urandom, 3'($urandom), '0, rr);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q.size() != 0 || m_stage_v) && k < 20) begin
            idle(1);
            k++;
        end
        n_cmp++;
        if (q.size() != 0 || m_stage_v) begin
            n_err++; $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
    endtask

    task automatic do_reset();
        rst = 1; req_valid = 0; rsp_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %0b expected 1", req_ready); end
        n_cmp++;
        if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %0b expected 0", rsp_valid); end
        n_cmp++;
        if (alu_control !== 3'd0 || alu_input1 !== 16'd0 || alu_input2 !== 16'd0) begin
            n_err++; $display("FAIL reset_alu_drive: got %0h %0h %0h expected 0 0 0", alu_input1, alu_input2, alu_control);
        end
        n_cmp++;
        if (err_cnt !== 8'd0) begin n_err++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
        n_cmp++;
        if (rsp_data !== 16'd0 || rsp_zero !== 1'b0 || rsp_tag !== '0) begin
            n_err++; $display("FAIL reset_rsp_payload: got %0h %0b %0h expected 0 0 0", rsp_data, rsp_zero, rsp_tag);
        end
    endtask

    task automatic test_single_add();
        step(1, 16'd5, 16'd6, 3'd0, 4'd3, 1);
        n_cmp++;
        if (alu_input1 !== 16'd5 || alu_input2 !== 16'd6 || alu_control !== 3'd0) begin
            n_err++; $display("FAIL add_alu_inputs: got %0d %0d %0d expected 5 6 0", alu_input1, alu_input2, alu_control);
        end
        idle(1);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'd11 || rsp_zero !== 1'b0 || rsp_tag !== 4'd3) begin
            n_err++; $display("FAIL add_rsp: got v=%0b d=%0d z=%0b t=%0d expected v=1 d=11 z=0 t=3",
                              rsp_valid, rsp_data, rsp_zero, rsp_tag);
        end
        drain();
    endtask

    task automatic test_sub_zero();
        step(1, 16'd5, 16'd5, 3'd1, 4'd9, 0);
        idle(0);
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'd0 || rsp_zero !== 1'b1 || rsp_tag !== 4'd9) begin
            n_err++; $display("FAIL sub_rsp: got v=%0b d=%0d z=%0b t=%0d expected v=1 d=0 z=1 t=9",
                              rsp_valid, rsp_data, rsp_zero, rsp_tag);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int idx;
        int k;
        do_reset();
        popped.delete();
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 16'(idx * 7), 16'(idx + 1), 3'd0, 4'(idx), 0);
            if (last_acc) idx++;
        end
        n_cmp++;
        if (idx !== 2) begin n_err++; $display("FAIL bp_accepted: got %0d expected 2", idx); end
        n_cmp++;
        if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_low: got %0b expected 0", req_ready); end
        k = 0;
        while (popped.size() < 4 && k < 40) begin
            if (idx < 4) begin
                step(1, 16'(idx * 7), 16'(idx + 1), 3'd0, 4'(idx), 1);
                if (last_acc) idx++;
            end else begin
                idle(1);
            end
            k++;
        end
        n_cmp++;
        if (popped.size() != 4) begin
            n_err++; $display("FAIL bp_count: got %0d expected 4", popped.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (popped[i] !== 4'(i)) begin
                    n_err++; $display("FAIL bp_order[%0d]: got %0d expected %0d", i, popped[i], i);
                end
            end
        end
    endtask

    task automatic test_full_simul();
        int   tag;
        logic [TAG_W-1:0] d;
        do_reset();
        popped.delete();
        tag = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, $urandom, $urandom, 3'($urandom), 4'(tag), 0);
            if (last_acc) tag++;
        end
        n_cmp++;
        if (q.size() != DEPTH || rsp_valid !== 1'b1) begin
            n_err++; $display("FAIL full_fill: got %0d entries expected %0d", q.size(), DEPTH);
        end
        for (int i = 0; i < 16; i++) begin
            step(1, $urandom, $urandom, 3'($urandom), 4'(tag), 1);
            if (last_acc) tag++;
        end
        drain();
        n_cmp++;
        if (popped.size() != tag) begin
            n_err++; $display("FAIL full_count: got %0d expected %0d", popped.size(), tag);
        end
        for (int i = 1; i < popped.size(); i++) begin
            d = popped[i] - popped[i-1];
            n_cmp++;
            if (d !== 4'd1) begin
                n_err++; $display("FAIL full_contig[%0d]: got %0d expected %0d", i, popped[i], 4'(popped[i-1] + 1));
            end
        end
    endtask

    task automatic test_random();
        int   tag;
        logic [TAG_W-1:0] d;
        do_reset();
        popped.delete();
        tag = 0;
        for (int i = 0; i < 300; i++) begin
            step(($urandom % 4) != 0, $urandom, $urandom, 3'($urandom), 4'(tag), ($urandom % 3) != 0);
            if (last_acc) tag++;
        end
        drain();
        n_cmp++;
        if (popped.size() != tag) begin
            n_err++; $display("FAIL rand_count: got %0d expected %0d", popped.size(), tag);
        end
        for (int i = 1; i < popped.size(); i++) begin
            d = popped[i] - popped[i-1];
            if (d !== 4'd1) begin
                n_cmp++; n_err++;
                $display("FAIL rand_order[%0d]: got %0d expected %0d", i, popped[i], 4'(popped[i-1] + 1));
            end
        end
    endtask

    task automatic test_checker();
        int exp_err;
`ifdef ALU_SEQ_CHECK_EN
        exp_err = 1;
`else
        exp_err = 0;
`endif
        do_reset();
        alu_bad = 1;
        step(1, 16'd5, 16'd6, 3'd0, 4'd1, 0);
        idle(0);
        alu_bad = 0;
        n_cmp++;
        if (rsp_data !== 16'd12 || rsp_tag !== 4'd1) begin
            n_err++; $display("FAIL chk_data: got %0d tag %0d expected 12 tag 1", rsp_data, rsp_tag);
        end
        n_cmp++;
        if (err_cnt !== 8'(exp_err)) begin
            n_err++; $display("FAIL chk_err_cnt: got %0d expected %0d", err_cnt, exp_err);
        end
        step(1, 16'd5, 16'd6, 3'd0, 4'd2, 1);
        drain();
    endtask

    task automatic test_reset_midstream();
        step(1, 16'd1, 16'd2, 3'd0, 4'd4, 0);
        step(1, 16'd3, 16'd4, 3'd1, 4'd5, 0);
        idle(0);
        n_cmp++;
        if (q.size() != 2 || rsp_valid !== 1'b1) begin
            n_err++; $display("FAIL mid_queued: got valid=%0b expected 1 with 2 queued", rsp_valid);
        end
        rst = 1; req_valid = 0; rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_clear();
        n_cmp++;
        if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_rsp_valid: got %0b expected 0", rsp_valid); end
        n_cmp++;
        if (err_cnt !== 8'd0) begin n_err++; $display("FAIL mid_err_cnt: got %0d expected 0", err_cnt); end
        popped.delete();
        for (int t = 8; t < 11; t++) begin
            step(1, $urandom, $urandom, 3'($urandom), 4'(t), 1);
            if (!last_acc) step(1, $urandom, $urandom, 3'($urandom), 4'(t), 1);
        end
        drain();
        n_cmp++;
        if (popped.size() != 3) begin
            n_err++; $display("FAIL mid_count: got %0d expected 3", popped.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (popped[i] !== 4'(8 + i)) begin
                    n_err++; $display("FAIL mid_tag[%0d]: got %0d expected %0d", i, popped[i], 8 + i);
                end
            end
        end
    endtask

    initial begin
        rst = 1; req_valid = 0; req_a = '0; req_b = '0; req_op = '0; req_tag = '0; rsp_ready = 0;
        model_clear();
        test_reset();
        test_single_add();
        test_sub_zero();
        test_backpressure();
        test_full_simul();
        test_random();
        test_checker();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
